chip8_mem_responder: RTL and testbench

//  Responder end of the chip-8 valid/ready memory interface. Serves requests from one initiator
//  (video engine or CPU) against RAM and double-buffered VRAM BRAMs. Owns the draw/display buffer

---
 rtl/chip8_pkg.sv | 21 ++
 rtl/chip8_mem_responder_if.sv | 23 ++
 rtl/chip8_buffer_copier.sv | 68 ++++++
 rtl/chip8_mem_responder.sv | 224 ++++++++++++++++++++++
 tb/tb_chip8_mem_responder.sv | 370 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/chip8_pkg.sv
// Shared definitions for the chip-8 memory responder slice.
// Holds the request target encoding, the VRAM buffer size and the responder FSM states.
// Imported by the responder top and by the buffer copier.
package chip8_pkg;

  // Request target select carried on req_type_in.
  localparam logic MEM_TYPE_RAM  = 1'b0;
  localparam logic MEM_TYPE_VRAM = 1'b1;

  // One VRAM buffer: 32 rows x 8 column bytes.
  localparam int VRAM_BYTES = 256;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RD_WAIT   = 3'd1,
    ST_COPY_RD   = 3'd2,
    ST_COPY_WAIT = 3'd3,
    ST_COPY_WR   = 3'd4
  } resp_state_e;

endpackage

// File: rtl/chip8_mem_responder_if.sv
// Request/response bus between one chip-8 memory initiator and the responder.
// master: drives req_*, samples req_ready_out / resp_*. slave: the reverse.
// A request is a single-cycle req_valid_in strobe, legal only while req_ready_out is high.
interface chip8_mem_responder_if;
  logic        req_valid_in;   // one-cycle request strobe
  logic        req_we_in;      // 1 write, 0 read
  logic        req_type_in;    // MEM_TYPE_RAM / MEM_TYPE_VRAM
  logic [15:0] req_addr_in;    // byte address, upper bits ignored by the responder
  logic [7:0]  req_data_in;    // write data
  logic        req_ready_out;  // next request may be issued
  logic        resp_valid_out; // one-cycle read-data pulse
  logic [7:0]  resp_data_out;  // read data, valid with resp_valid_out

  modport master (
    output req_valid_in, req_we_in, req_type_in, req_addr_in, req_data_in,
    input  req_ready_out, resp_valid_out, resp_data_out
  );

  modport slave (
    input  req_valid_in, req_we_in, req_type_in, req_addr_in, req_data_in,
    output req_ready_out, resp_valid_out, resp_data_out
  );
endinterface

// File: rtl/chip8_buffer_copier.sv
// Copy engine datapath: byte index counter, read-latency wait counter and the VRAM port
// it drives while a display->draw buffer copy is in progress.
// Latency: one byte per (VRAM_LATENCY+1) cycles; phase strobes come from the parent FSM.
// Backpressure: none; the parent holds req_ready low for the whole copy.
// Ports: clk_i/rst_i; start_i clears the index; rd_i/wait_i/wr_i mark the current phase;
//   draw_buf_i is the (already toggled) draw buffer; vram_dout_i is BRAM read data;
//   wait_done_o ends COPY_WAIT; done_o flags the final write; vram_*_o is the copy's port.
module chip8_buffer_copier
  import chip8_pkg::*;
#(
  parameter int VRAM_LATENCY = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic       rd_i,
  input  logic       wait_i,
  input  logic       wr_i,
  input  logic       draw_buf_i,
  input  logic [7:0] vram_dout_i,
  output logic       wait_done_o,
  output logic       done_o,
  output logic [8:0] vram_addr_o,
  output logic       vram_we_o,
  output logic [7:0] vram_din_o
);

  // COPY_WAIT lasts VRAM_LATENCY-1 cycles; the counter is loaded in COPY_RD so that it
  // reaches zero in the last wait cycle.
  localparam int WAIT_LOAD = (VRAM_LATENCY > 1) ? (VRAM_LATENCY - 2) : 0;

  logic [7:0] idx_q, idx_d;
  logic [7:0] wait_q, wait_d;

  always_comb begin
    idx_d  = idx_q;
    wait_d = wait_q;
    if (start_i) begin
      idx_d = 8'd0;
    end else if (wr_i) begin
      idx_d = idx_q + 8'd1;
    end
    if (rd_i) begin
      wait_d = 8'(WAIT_LOAD);
    end else if (wait_i && (wait_q != 8'd0)) begin
      wait_d = wait_q - 8'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      idx_q  <= 8'd0;
      wait_q <= 8'd0;
    end else begin
      idx_q  <= idx_d;
      wait_q <= wait_d;
    end
  end

  assign wait_done_o = (wait_q == 8'd0);
  assign done_o      = wr_i && (idx_q == 8'(VRAM_BYTES - 1));

  // Read from the display buffer, write the returned byte into the draw buffer.
  assign vram_addr_o = wr_i ? {draw_buf_i, idx_q} : {~draw_buf_i, idx_q};
  assign vram_we_o   = wr_i;
  assign vram_din_o  = wr_i ? vram_dout_i : 8'd0;

endmodule

// File: rtl/chip8_mem_responder.sv
// Responder end of the chip-8 memory bus: serves RAM and double-buffered VRAM, owns the
// draw/display select and refreshes the draw buffer from the display buffer on swap.
// Latency: writes 0 wait states; reads respond LATENCY+1 cycles after accept; copy 768 cycles.
// Backpressure: req_ready_out low while a read or copy is outstanding; extra requests dropped.
// Ports: clk_in/rst_in; bus (slave) request/response; ram_* and vram_* BRAM ports with
//   registered addr/we/din; swap_in swap pulse; draw_buf_out, copy_busy_out, protocol_err_out.
module chip8_mem_responder
  import chip8_pkg::*;
#(
  parameter int RAM_LATENCY  = 2,
  parameter int VRAM_LATENCY = 2,
  parameter int RAM_AW       = 12
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  chip8_mem_responder_if.slave  bus,
  output logic [RAM_AW-1:0]     ram_addr_out,
  output logic                  ram_we_out,
  output logic [7:0]            ram_din_out,
  input  logic [7:0]            ram_dout_in,
  output logic [8:0]            vram_addr_out,
  output logic                  vram_we_out,
  output logic [7:0]            vram_din_out,
  input  logic [7:0]            vram_dout_in,
  input  logic                  swap_in,
  output logic                  draw_buf_out,
  output logic                  copy_busy_out,
  output logic                  protocol_err_out
);

  resp_state_e       state_q, state_d;
  logic              ready_q, ready_d;
  logic              resp_valid_q, resp_valid_d;
  logic              copy_busy_q, copy_busy_d;
  logic              draw_buf_q, draw_buf_d;
  logic              swap_pend_q, swap_pend_d;
  logic              perr_q, perr_d;
  logic              rd_type_q, rd_type_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [RAM_AW-1:0] ram_addr_q, ram_addr_d;
  logic              ram_we_q, ram_we_d;
  logic [7:0]        ram_din_q, ram_din_d;
  logic [8:0]        vram_addr_q, vram_addr_d;
  logic              vram_we_q, vram_we_d;
  logic [7:0]        vram_din_q, vram_din_d;

  logic              accept;
  logic              take;
  logic              cp_rd, cp_wait, cp_wr;
  logic              cp_wait_done, cp_done;
  logic [8:0]        cp_vram_addr;
  logic              cp_vram_we;
  logic [7:0]        cp_vram_din;
  logic              unused_addr_bits;

  assign accept = bus.req_valid_in & ready_q;
  // A request accepted this cycle beats a pending swap; the swap waits for a free IDLE cycle.
  assign take    = (state_q == ST_IDLE) & ~accept & swap_pend_q;
  assign cp_rd   = (state_q == ST_COPY_RD);
  assign cp_wait = (state_q == ST_COPY_WAIT);
  assign cp_wr   = (state_q == ST_COPY_WR);

  // Address bits above the decoded range are deliberately ignored (address wraps).
  assign unused_addr_bits = ^bus.req_addr_in;

  chip8_buffer_copier #(
    .VRAM_LATENCY (VRAM_LATENCY)
  ) u_copier (
    .clk_i       (clk_in),
    .rst_i       (rst_in),
    .start_i     (take),
    .rd_i        (cp_rd),
    .wait_i      (cp_wait),
    .wr_i        (cp_wr),
    .draw_buf_i  (draw_buf_q),
    .vram_dout_i (vram_dout_in),
    .wait_done_o (cp_wait_done),
    .done_o      (cp_done),
    .vram_addr_o (cp_vram_addr),
    .vram_we_o   (cp_vram_we),
    .vram_din_o  (cp_vram_din)
  );

  always_comb begin
    state_d      = state_q;
    ready_d      = ready_q;
    resp_valid_d = 1'b0;
    copy_busy_d  = copy_busy_q;
    draw_buf_d   = draw_buf_q;
    swap_pend_d  = swap_pend_q | swap_in;
    perr_d       = perr_q | (bus.req_valid_in & ~ready_q);
    rd_type_d    = rd_type_q;
    cnt_d        = cnt_q;
    ram_addr_d   = ram_addr_q;
    ram_we_d     = 1'b0;
    ram_din_d    = ram_din_q;
    vram_addr_d  = vram_addr_q;
    vram_we_d    = 1'b0;
    vram_din_d   = vram_din_q;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (bus.req_type_in == MEM_TYPE_VRAM) begin
            vram_addr_d = {draw_buf_q, bus.req_addr_in[7:0]};
            vram_we_d   = bus.req_we_in;
            vram_din_d  = bus.req_data_in;
          end else begin
            ram_addr_d = bus.req_addr_in[RAM_AW-1:0];
            ram_we_d   = bus.req_we_in;
            ram_din_d  = bus.req_data_in;
          end
          if (!bus.req_we_in) begin
            state_d   = ST_RD_WAIT;
            ready_d   = 1'b0;
            rd_type_d = bus.req_type_in;
            // Counts down to the last cycle before read data arrives.
            cnt_d     = (bus.req_type_in == MEM_TYPE_VRAM) ? 8'(VRAM_LATENCY - 1)
                                                           : 8'(RAM_LATENCY - 1);
          end
        end else begin
          // Also raises ready on the first cycle out of reset.
          ready_d = 1'b1;
          if (take) begin
            state_d     = ST_COPY_RD;
            ready_d     = 1'b0;
            copy_busy_d = 1'b1;
            draw_buf_d  = ~draw_buf_q;
            swap_pend_d = swap_in;
          end
        end
      end

      ST_RD_WAIT: begin
        if (cnt_q == 8'd0) begin
          state_d      = ST_IDLE;
          resp_valid_d = 1'b1;
          ready_d      = 1'b1;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end

      ST_COPY_RD: begin
        state_d = (VRAM_LATENCY > 1) ? ST_COPY_WAIT : ST_COPY_WR;
      end

      ST_COPY_WAIT: begin
        if (cp_wait_done) begin
          state_d = ST_COPY_WR;
        end
      end

      ST_COPY_WR: begin
        if (cp_done) begin
          state_d     = ST_IDLE;
          ready_d     = 1'b1;
          copy_busy_d = 1'b0;
        end else begin
          state_d = ST_COPY_RD;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q      <= ST_IDLE;
      ready_q      <= 1'b0;
      resp_valid_q <= 1'b0;
      copy_busy_q  <= 1'b0;
      draw_buf_q   <= 1'b0;
      swap_pend_q  <= 1'b0;
      perr_q       <= 1'b0;
      rd_type_q    <= MEM_TYPE_RAM;
      cnt_q        <= 8'd0;
      ram_addr_q   <= '0;
      ram_we_q     <= 1'b0;
      ram_din_q    <= 8'd0;
      vram_addr_q  <= 9'd0;
      vram_we_q    <= 1'b0;
      vram_din_q   <= 8'd0;
    end else begin
      state_q      <= state_d;
      ready_q      <= ready_d;
      resp_valid_q <= resp_valid_d;
      copy_busy_q  <= copy_busy_d;
      draw_buf_q   <= draw_buf_d;
      swap_pend_q  <= swap_pend_d;
      perr_q       <= perr_d;
      rd_type_q    <= rd_type_d;
      cnt_q        <= cnt_d;
      ram_addr_q   <= ram_addr_d;
      ram_we_q     <= ram_we_d;
      ram_din_q    <= ram_din_d;
      vram_addr_q  <= vram_addr_d;
      vram_we_q    <= vram_we_d;
      vram_din_q   <= vram_din_d;
    end
  end

  assign bus.req_ready_out  = ready_q;
  assign bus.resp_valid_out = resp_valid_q;
  // BRAM data arrives in the response cycle itself, so it is passed through, gated to 0.
  assign bus.resp_data_out  = resp_valid_q ? ((rd_type_q == MEM_TYPE_VRAM) ? vram_dout_in
                                                                            : ram_dout_in)
                                           : 8'd0;

  assign ram_addr_out  = ram_addr_q;
  assign ram_we_out    = ram_we_q;
  assign ram_din_out   = ram_din_q;
  assign vram_addr_out = copy_busy_q ? cp_vram_addr : vram_addr_q;
  assign vram_we_out   = copy_busy_q ? cp_vram_we   : vram_we_q;
  assign vram_din_out  = copy_busy_q ? cp_vram_din  : vram_din_q;

  assign draw_buf_out     = draw_buf_q;
  assign copy_busy_out    = copy_busy_q;
  assign protocol_err_out = perr_q;

endmodule

// File: tb/tb_chip8_mem_responder.sv
// Bench for chip8_mem_responder: behavioural BRAMs, array-based reference model of memory
// contents and buffer select, directed steps plus a randomized read/write mix.
module tb_chip8_mem_responder;
  import chip8_pkg::*;

  localparam int RAM_LATENCY  = 2;
  localparam int VRAM_LATENCY = 2;
  localparam int RAM_AW       = 12;
  localparam int COPY_CYCLES  = (VRAM_LATENCY + 1) * 256;

  logic              clk_in = 1'b0;
  logic              rst_in;
  logic [RAM_AW-1:0] ram_addr_out;
  logic              ram_we_out;
  logic [7:0]        ram_din_out;
  logic [7:0]        ram_dout_in;
  logic [8:0]        vram_addr_out;
  logic              vram_we_out;
  logic [7:0]        vram_din_out;
  logic [7:0]        vram_dout_in;
  logic              swap_in;
  logic              draw_buf_out;
  logic              copy_busy_out;
  logic              protocol_err_out;

  chip8_mem_responder_if bus();

  chip8_mem_responder #(
    .RAM_LATENCY  (RAM_LATENCY),
    .VRAM_LATENCY (VRAM_LATENCY),
    .RAM_AW       (RAM_AW)
  ) dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .bus              (bus),
    .ram_addr_out     (ram_addr_out),
    .ram_we_out       (ram_we_out),
    .ram_din_out      (ram_din_out),
    .ram_dout_in      (ram_dout_in),
    .vram_addr_out    (vram_addr_out),
    .vram_we_out      (vram_we_out),
    .vram_din_out     (vram_din_out),
    .vram_dout_in     (vram_dout_in),
    .swap_in          (swap_in),
    .draw_buf_out     (draw_buf_out),
    .copy_busy_out    (copy_busy_out),
    .protocol_err_out (protocol_err_out)
  );

  always #5 clk_in = ~clk_in;

  // Behavioural BRAMs: address sampled at the edge, data out LATENCY cycles after the
  // address is presented.
  logic [7:0] bram_ram  [4096];
  logic [7:0] bram_vram [512];
  logic [7:0] ram_pipe  [RAM_LATENCY];
  logic [7:0] vram_pipe [VRAM_LATENCY];

  always @(posedge clk_in) begin
    if (ram_we_out) bram_ram[ram_addr_out] <= ram_din_out;
    ram_pipe[0] <= bram_ram[ram_addr_out];
    for (int k = 1; k < RAM_LATENCY; k++) ram_pipe[k] <= ram_pipe[k-1];
    if (vram_we_out) bram_vram[vram_addr_out] <= vram_din_out;
    vram_pipe[0] <= bram_vram[vram_addr_out];
    for (int k = 1; k < VRAM_LATENCY; k++) vram_pipe[k] <= vram_pipe[k-1];
  end

  assign ram_dout_in  = ram_pipe[RAM_LATENCY-1];
  assign vram_dout_in = vram_pipe[VRAM_LATENCY-1];

  // Reference model: what each memory location should hold and which buffer is drawn.
  logic [7:0] exp_ram  [4096];
  logic [7:0] exp_vram [512];
  logic       exp_db;
  int         ram_known_q[$];
  int         vram_known_q[$];

  int vectors     = 0;
  int miscompares = 0;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, vectors=%0d", vectors);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, {bus.req_ready_out, bus.resp_valid_out, bus.resp_data_out, ram_addr_out,
                ram_we_out, ram_din_out, vram_addr_out, vram_we_out, vram_din_out,
                draw_buf_out, copy_busy_out, protocol_err_out}, 64'd0);
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (bus.req_ready_out !== 1'b1 && n < 3000) begin
      tick();
      n++;
    end
    check({tag, "_ready"}, 64'(bus.req_ready_out), 64'd1);
  endtask

  // Model of a swap being taken: flip the draw buffer, then it mirrors the display buffer.
  task automatic model_swap();
    exp_db = ~exp_db;
    for (int i = 0; i < 256; i++) exp_vram[{exp_db, 8'(i)}] = exp_vram[{~exp_db, 8'(i)}];
  endtask

  task automatic write_req(input logic typ, input logic [15:0] a, input logic [7:0] d);
    wait_ready("wr");
    bus.req_valid_in = 1'b1;
    bus.req_we_in    = 1'b1;
    bus.req_type_in  = typ;
    bus.req_addr_in  = a;
    bus.req_data_in  = d;
    tick();
    bus.req_valid_in = 1'b0;
    if (typ == MEM_TYPE_RAM) exp_ram[a[11:0]] = d;
    else                     exp_vram[{exp_db, a[7:0]}] = d;
  endtask

  task automatic read_req(input string tag, input logic typ, input logic [15:0] a);
    logic [7:0] exp_d;
    int         n;
    int         lat;
    exp_d = (typ == MEM_TYPE_RAM) ? exp_ram[a[11:0]] : exp_vram[{exp_db, a[7:0]}];
    lat   = (typ == MEM_TYPE_RAM) ? RAM_LATENCY : VRAM_LATENCY;
    wait_ready(tag);
    bus.req_valid_in = 1'b1;
    bus.req_we_in    = 1'b0;
    bus.req_type_in  = typ;
    bus.req_addr_in  = a;
    bus.req_data_in  = 8'($urandom);
    tick();
    bus.req_valid_in = 1'b0;
    check({tag, "_busy_after_accept"}, 64'(bus.req_ready_out), 64'd0);
    if (typ == MEM_TYPE_RAM) check({tag, "_ram_addr"}, {ram_we_out, ram_addr_out}, {1'b0, a[11:0]});
    else check({tag, "_vram_addr"}, {vram_we_out, vram_addr_out}, {1'b0, exp_db, a[7:0]});
    n = 1;
    while (bus.resp_valid_out !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    check({tag, "_latency"}, 64'(n), 64'(lat + 1));
    check({tag, "_data"}, 64'(bus.resp_data_out), 64'(exp_d));
    check({tag, "_ready_at_resp"}, 64'(bus.req_ready_out), 64'd1);
  endtask

  // Counts cycles with copy_busy high from the current cycle; flags client-side activity.
  task automatic count_busy(output int n, output int viol);
    n = 0;
    viol = 0;
    while (copy_busy_out === 1'b1 && n < 2000) begin
      if (ram_we_out !== 1'b0 || bus.resp_valid_out !== 1'b0 || bus.req_ready_out !== 1'b0) viol++;
      tick();
      n++;
    end
  endtask

  initial begin
    int         n;
    int         viol;
    int         bad;
    int         c;
    logic [15:0] a;
    logic [7:0]  d;

    rst_in           = 1'b1;
    swap_in          = 1'b0;
    bus.req_valid_in = 1'b0;
    bus.req_we_in    = 1'b0;
    bus.req_type_in  = 1'b0;
    bus.req_addr_in  = 16'd0;
    bus.req_data_in  = 8'd0;
    exp_db           = 1'b0;

    // Reset state.
    repeat (3) tick();
    check_all_zero("reset_outputs");
    rst_in = 1'b0;
    tick();
    check("ready_after_reset", 64'(bus.req_ready_out), 64'd1);
    check("perr_after_reset", 64'(protocol_err_out), 64'd0);

    // RAM write then read.
    write_req(MEM_TYPE_RAM, 16'h0200, 8'hA2);
    read_req("ram_200", MEM_TYPE_RAM, 16'h0200);

    // Back-to-back VRAM writes land on consecutive cycles.
    wait_ready("b2b");
    bus.req_valid_in = 1'b1;
    bus.req_we_in    = 1'b1;
    bus.req_type_in  = MEM_TYPE_VRAM;
    bus.req_addr_in  = 16'h0005;
    bus.req_data_in  = 8'hF0;
    tick();
    check("b2b_first", {vram_we_out, vram_addr_out, vram_din_out, bus.req_ready_out},
          {1'b1, 9'h005, 8'hF0, 1'b1});
    bus.req_addr_in  = 16'h0006;
    bus.req_data_in  = 8'h0F;
    tick();
    bus.req_valid_in = 1'b0;
    check("b2b_second", {vram_we_out, vram_addr_out, vram_din_out, bus.req_ready_out},
          {1'b1, 9'h006, 8'h0F, 1'b1});
    exp_vram[9'h005] = 8'hF0;
    exp_vram[9'h006] = 8'h0F;
    read_req("vram_005", MEM_TYPE_VRAM, 16'h0005);
    read_req("vram_006", MEM_TYPE_VRAM, 16'h0006);

    // Upper address bits ignored.
    read_req("ram_F200", MEM_TYPE_RAM, 16'hF200);

    // Randomized mix of reads and writes against the model.
    ram_known_q.push_back(12'h200);
    vram_known_q.push_back(5);
    vram_known_q.push_back(6);
    for (int k = 0; k < 80; k++) begin
      case ($urandom_range(0, 3))
        0: begin
          a = 16'($urandom);
          write_req(MEM_TYPE_RAM, a, 8'($urandom));
          ram_known_q.push_back(int'(a[11:0]));
        end
        1: begin
          a = 16'($urandom);
          write_req(MEM_TYPE_VRAM, a, 8'($urandom));
          vram_known_q.push_back(int'(a[7:0]));
        end
        2: begin
          a = {4'($urandom), 12'(ram_known_q[$urandom_range(0, ram_known_q.size() - 1)])};
          read_req("rnd_ram", MEM_TYPE_RAM, a);
        end
        default: begin
          a = {8'($urandom), 8'(vram_known_q[$urandom_range(0, vram_known_q.size() - 1)])};
          read_req("rnd_vram", MEM_TYPE_VRAM, a);
        end
      endcase
    end

    // Fill draw buffer 0 with i^0x55, back-to-back.
    wait_ready("fill");
    for (int i = 0; i < 256; i++) begin
      bus.req_valid_in = 1'b1;
      bus.req_we_in    = 1'b1;
      bus.req_type_in  = MEM_TYPE_VRAM;
      bus.req_addr_in  = 16'(i);
      bus.req_data_in  = 8'(i) ^ 8'h55;
      exp_vram[{exp_db, 8'(i)}] = 8'(i) ^ 8'h55;
      tick();
    end
    bus.req_valid_in = 1'b0;

    // Swap: latched, taken next free IDLE cycle, copy for COPY_CYCLES cycles.
    swap_in = 1'b1;
    tick();
    swap_in = 1'b0;
    n = 0;
    while (copy_busy_out !== 1'b1 && n < 5) begin
      tick();
      n++;
    end
    check("swap_take_delay", 64'(n), 64'd1);
    check("draw_buf_after_swap", 64'(draw_buf_out), 64'd1);
    model_swap();
    count_busy(n, viol);
    check("copy_length", 64'(n), 64'(COPY_CYCLES));
    check("copy_no_client_activity", 64'(viol), 64'd0);
    check("ready_after_copy", 64'(bus.req_ready_out), 64'd1);
    bad = 0;
    for (int i = 0; i < 256; i++) if (bram_vram[256 + i] !== exp_vram[256 + i]) bad++;
    check("copy_contents", 64'(bad), 64'd0);
    for (int k = 0; k < 4; k++) read_req("post_copy_vram", MEM_TYPE_VRAM, 16'($urandom));

    // Swap arriving with a read accept: read first, copy after; two swaps in copy -> one more.
    write_req(MEM_TYPE_RAM, 16'h0345, 8'h3C);
    wait_ready("rd_swap");
    bus.req_valid_in = 1'b1;
    bus.req_we_in    = 1'b0;
    bus.req_type_in  = MEM_TYPE_RAM;
    bus.req_addr_in  = 16'h0345;
    swap_in          = 1'b1;
    tick();
    bus.req_valid_in = 1'b0;
    swap_in          = 1'b0;
    n = 1;
    while (bus.resp_valid_out !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    check("rd_swap_latency", 64'(n), 64'(RAM_LATENCY + 1));
    check("rd_swap_data", 64'(bus.resp_data_out), 64'h3C);
    check("rd_swap_no_copy_yet", 64'(copy_busy_out), 64'd0);
    tick();
    check("rd_swap_copy_start", {copy_busy_out, draw_buf_out}, {1'b1, ~exp_db});
    model_swap();
    c = 0;
    while (copy_busy_out === 1'b1 && c < 2000) begin
      swap_in = (c == 10 || c == 200);
      tick();
      c++;
    end
    swap_in = 1'b0;
    check("rd_swap_copy_length", 64'(c), 64'(COPY_CYCLES));
    check("gap_ready", 64'(bus.req_ready_out), 64'd1);
    tick();
    check("collapsed_swap_copy", {copy_busy_out, draw_buf_out}, {1'b1, ~exp_db});
    model_swap();
    count_busy(n, viol);
    check("collapsed_copy_length", 64'(n), 64'(COPY_CYCLES));
    check("collapsed_copy_no_client", 64'(viol), 64'd0);
    repeat (5) tick();
    check("no_third_copy", {copy_busy_out, bus.req_ready_out}, {1'b0, 1'b1});
    read_req("vram_after_double", MEM_TYPE_VRAM, 16'h0077);

    // Request while busy: dropped, sticky protocol error.
    write_req(MEM_TYPE_RAM, 16'h0123, 8'h11);
    check("perr_clean", 64'(protocol_err_out), 64'd0);
    wait_ready("perr");
    bus.req_valid_in = 1'b1;
    bus.req_we_in    = 1'b0;
    bus.req_type_in  = MEM_TYPE_RAM;
    bus.req_addr_in  = 16'h0123;
    tick();
    bus.req_we_in    = 1'b1;
    bus.req_data_in  = 8'h99;
    tick();
    bus.req_valid_in = 1'b0;
    check("perr_set", {protocol_err_out, ram_we_out}, {1'b1, 1'b0});
    n = 2;
    while (bus.resp_valid_out !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    check("perr_read_latency", 64'(n), 64'(RAM_LATENCY + 1));
    check("perr_read_data", 64'(bus.resp_data_out), 64'h11);
    read_req("perr_dropped_write", MEM_TYPE_RAM, 16'h0123);
    check("perr_sticky", 64'(protocol_err_out), 64'd1);

    // Reset in the middle of a copy.
    swap_in = 1'b1;
    tick();
    swap_in = 1'b0;
    repeat (60) tick();
    check("copy_running_before_reset", 64'(copy_busy_out), 64'd1);
    rst_in = 1'b1;
    tick();
    check_all_zero("reset_mid_copy");
    rst_in = 1'b0;
    tick();
    check("ready_after_mid_reset", {bus.req_ready_out, copy_busy_out}, {1'b1, 1'b0});
    repeat (3) tick();
    check("no_copy_after_reset", {copy_busy_out, draw_buf_out}, {1'b0, 1'b0});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
